// File: rtl/anpc_pkg.sv
// Shared encodings for the 3-level ANPC scheduler: level codes, commutation
// types, commutation-mode selectors and scheduler state encoding.
package anpc_pkg;

   localparam logic [1:0] LEV_ZERO = 2'd0;
   localparam logic [1:0] LEV_P    = 2'd1;
   localparam logic [1:0] LEV_N    = 2'd2;

   localparam logic [1:0] TYPE_I   = 2'd0;
   localparam logic [1:0] TYPE_IU  = 2'd1;
   localparam logic [1:0] TYPE_II  = 2'd2;
   localparam logic [1:0] TYPE_III = 2'd3;

   localparam logic [1:0] MODE_FIX_I  = 2'd0;
   localparam logic [1:0] MODE_FIX_II = 2'd1;
   localparam logic [1:0] MODE_ALT    = 2'd2;
   localparam logic [1:0] MODE_ISIGN  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READY  = 3'd1,
      ST_DWELL  = 3'd2,
      ST_BRIDGE = 3'd3,
      ST_FAULT  = 3'd4
   } sched_st_t;

endpackage

// File: rtl/anpc_dwell_timer.sv
// Dwell down-counter: clear beats load beats decrement; holds at zero and
// whenever ce is low.
module anpc_dwell_timer #(
   parameter int TW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          load,
   input  logic          clr,
   input  logic          dec,
   input  logic [TW-1:0] load_val,
   output logic [TW-1:0] cnt,
   output logic          zero
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (ce) begin
         if (clr)
            cnt <= '0;
         else if (load)
            cnt <= load_val;
         else if (dec && (cnt != '0))
            cnt <= cnt - TW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/anpc_lev_scheduler.sv
// Level/commutation-type sequencer for the ANPC commutation FSM with dwell
// enforcement, P<->N zero bridging and trip handling. Optional: ANPC_SCHED_STATS_EN.
module anpc_lev_scheduler
   import anpc_pkg::*;
#(
   parameter int TW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          en,
   input  logic [1:0]    lev_req,
   input  logic [1:0]    comm_mode,
   input  logic          i_pos,
   input  logic [TW-1:0] t_dwell,
   input  logic          trip_in,
   output logic [1:0]    v_lev,
   output logic [1:0]    comm_type,
   output logic          busy,
   output logic          fault
`ifdef ANPC_SCHED_STATS_EN
   ,
   output logic [15:0]   sw_cnt
`endif
);

   sched_st_t     st, st_n;
   logic [1:0]    lev_n, tgt, tgt_n, req_eff, ct_n;
   logic          rot, rot_n, zero_entry, opp_jump;
   logic          tmr_load, tmr_clr, tmr_dec, tmr_zero;
   logic [TW-1:0] dwell_val, cnt;

   function automatic logic [1:0] sel_type(input logic [1:0] mode,
                                           input logic       rot_b,
                                           input logic       ipos);
      logic [1:0] t;
      t = TYPE_I;
      case (mode)
         MODE_FIX_I:  t = TYPE_I;
         MODE_FIX_II: t = TYPE_II;
         MODE_ALT:    t = rot_b ? TYPE_II : TYPE_I;
         MODE_ISIGN:  t = ipos ? TYPE_II : TYPE_I;
         default:     t = TYPE_I;
      endcase
      return t;
   endfunction

   assign req_eff   = (lev_req == 2'd3) ? LEV_ZERO : lev_req;
   assign dwell_val = (t_dwell == '0) ? '0 : (t_dwell - TW'(1));
   assign opp_jump  = ((v_lev == LEV_P) && (req_eff == LEV_N)) ||
                      ((v_lev == LEV_N) && (req_eff == LEV_P));

   anpc_dwell_timer #(.TW(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .load     (tmr_load),
      .clr      (tmr_clr),
      .dec      (tmr_dec),
      .load_val (dwell_val),
      .cnt      (cnt),
      .zero     (tmr_zero)
   );

   always_comb begin
      st_n     = st;
      lev_n    = v_lev;
      tgt_n    = tgt;
      tmr_load = 1'b0;
      tmr_clr  = 1'b0;
      tmr_dec  = 1'b0;
      case (st)
         ST_IDLE: begin
            lev_n = LEV_ZERO;
            if (en)
               st_n = ST_READY;
         end
         ST_READY: begin
            // With en low, park at zero through a full dwell before idling.
            if (!en) begin
               if (v_lev != LEV_ZERO) begin
                  lev_n    = LEV_ZERO;
                  tmr_load = 1'b1;
                  st_n     = ST_DWELL;
               end else begin
                  st_n = ST_IDLE;
               end
            end else if (req_eff != v_lev) begin
               tmr_load = 1'b1;
               if (opp_jump) begin
                  lev_n = LEV_ZERO;
                  tgt_n = req_eff;
                  st_n  = ST_BRIDGE;
               end else begin
                  lev_n = req_eff;
                  st_n  = ST_DWELL;
               end
            end
         end
         ST_DWELL: begin
            if (tmr_zero)
               st_n = ST_READY;
            else
               tmr_dec = 1'b1;
         end
         ST_BRIDGE: begin
            if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else if (en && (req_eff == tgt)) begin
               lev_n    = tgt;
               tmr_load = 1'b1;
               st_n     = ST_DWELL;
            end else begin
               st_n = ST_READY;
            end
         end
         ST_FAULT: begin
            lev_n = LEV_ZERO;
            if (!en)
               st_n = ST_IDLE;
         end
         default: begin
            lev_n = LEV_ZERO;
            st_n  = ST_IDLE;
         end
      endcase
      if (trip_in) begin
         lev_n    = LEV_ZERO;
         tmr_load = 1'b0;
         tmr_dec  = 1'b0;
         tmr_clr  = 1'b1;
         st_n     = ST_FAULT;
      end
   end

   // Commutation type is only re-chosen on a nonzero-to-zero level load.
   assign zero_entry = (lev_n == LEV_ZERO) && (v_lev != LEV_ZERO);

   always_comb begin
      ct_n  = comm_type;
      rot_n = rot;
      if (zero_entry) begin
         ct_n = sel_type(comm_mode, rot, i_pos);
         if (comm_mode == MODE_ALT)
            rot_n = ~rot;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= ST_IDLE;
         v_lev     <= LEV_ZERO;
         tgt       <= LEV_ZERO;
         comm_type <= TYPE_I;
         rot       <= 1'b0;
      end else if (ce) begin
         st        <= st_n;
         v_lev     <= lev_n;
         tgt       <= tgt_n;
         comm_type <= ct_n;
         rot       <= rot_n;
      end
   end

   assign busy  = (cnt != '0);
   assign fault = (st == ST_FAULT);

`ifdef ANPC_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sw_cnt <= '0;
      else if (ce) begin
         if (trip_in && (st != ST_FAULT))
            sw_cnt <= '0;
         else if (lev_n != v_lev)
            sw_cnt <= sw_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_anpc_lev_scheduler.sv
// Directed self-checking bench for anpc_lev_scheduler (hand-computed vectors).
module tb_anpc_lev_scheduler;

   localparam int TW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic          en;
   logic [1:0]    lev_req;
   logic [1:0]    comm_mode;
   logic          i_pos;
   logic [TW-1:0] t_dwell;
   logic          trip_in;
   logic [1:0]    v_lev;
   logic [1:0]    comm_type;
   logic          busy;
   logic          fault;
`ifdef ANPC_SCHED_STATS_EN
   logic [15:0]   sw_cnt;
`endif

   int total = 0;
   int bad   = 0;

   anpc_lev_scheduler #(.TW(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .en        (en),
      .lev_req   (lev_req),
      .comm_mode (comm_mode),
      .i_pos     (i_pos),
      .t_dwell   (t_dwell),
      .trip_in   (trip_in),
      .v_lev     (v_lev),
      .comm_type (comm_type),
      .busy      (busy),
      .fault     (fault)
`ifdef ANPC_SCHED_STATS_EN
      ,
      .sw_cnt    (sw_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; en = 1'b0; lev_req = 2'd0; comm_mode = 2'd0;
      i_pos = 1'b0; t_dwell = 10'd4; trip_in = 1'b0;
      repeat (3) tick();
      chk("rst_vlev", v_lev, 0);
      chk("rst_ctype", comm_type, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fault", fault, 0);
      rst = 1'b0;

      // Dwell of 4: busy for 3 cycles, later request ignored until READY
      en = 1'b1; tick();
      lev_req = 2'd1; tick();
      chk("t1_vlev_load", v_lev, 1);
      chk("t1_busy0", busy, 1);
      lev_req = 2'd2;
      tick(); chk("t1_busy1", busy, 1); chk("t1_hold1", v_lev, 1);
      tick(); chk("t1_busy2", busy, 1); chk("t1_hold2", v_lev, 1);
      tick(); chk("t1_busy3", busy, 0); chk("t1_hold3", v_lev, 1);
      tick(); chk("t1_hold4", v_lev, 1);
      lev_req = 2'd1;
      tick(); chk("t1_same", v_lev, 1); chk("t1_idle_busy", busy, 0);

      // P -> N bridges through zero for 3 cycles
      t_dwell = 10'd3; comm_mode = 2'd1; lev_req = 2'd2;
      tick(); chk("t2_zero0", v_lev, 0); chk("t2_ctype", comm_type, 2);
      tick(); chk("t2_zero1", v_lev, 0);
      tick(); chk("t2_zero2", v_lev, 0);
      tick(); chk("t2_n", v_lev, 2);
      repeat (3) tick();

      // Alternating commutation type across four zero entries
      t_dwell = 10'd1; lev_req = 2'd0;
      tick(); chk("t3_n2z", v_lev, 0);
      tick();
      comm_mode = 2'd2;
      for (int i = 0; i < 4; i++) begin
         lev_req = 2'd1; tick(); chk("t3_p", v_lev, 1);
         tick();
         lev_req = 2'd0; tick();
         chk("t3_alt", comm_type, (i % 2 == 0) ? 0 : 2);
         tick();
      end

      // Current-sign selection
      comm_mode = 2'd3;
      i_pos = 1'b1; lev_req = 2'd1; tick(); tick();
      lev_req = 2'd0; tick(); chk("t4_ipos1", comm_type, 2); tick();
      i_pos = 1'b0; lev_req = 2'd1; tick(); tick();
      lev_req = 2'd0; tick(); chk("t4_ipos0", comm_type, 0); tick();

      // Trip during dwell at N
      t_dwell = 10'd5; lev_req = 2'd2;
      tick(); chk("t5_n", v_lev, 2);
      tick();
      trip_in = 1'b1; tick();
      chk("t5_trip_vlev", v_lev, 0); chk("t5_fault", fault, 1); chk("t5_trip_busy", busy, 0);
      trip_in = 1'b0; tick(); tick();
      chk("t5_stay", fault, 1); chk("t5_stay_vlev", v_lev, 0);
      en = 1'b0; tick();
      chk("t5_exit", fault, 0);
      en = 1'b1; lev_req = 2'd0; tick();

      // ce low freezes the dwell
      t_dwell = 10'd6; lev_req = 2'd1;
      tick(); chk("t6_p", v_lev, 1);
      tick();
      ce = 1'b0; lev_req = 2'd2;
      repeat (10) tick();
      chk("t6_frz_vlev", v_lev, 1); chk("t6_frz_busy", busy, 1);
      ce = 1'b1; lev_req = 2'd1;
      repeat (3) tick(); chk("t6_cnt1", busy, 1);
      tick(); chk("t6_cnt0", busy, 0);
      tick();

      // t_dwell = 0 acts as a one-cycle dwell
      t_dwell = 10'd0; lev_req = 2'd0;
      tick(); chk("t7_zero", v_lev, 0); chk("t7_nobusy", busy, 0);
      tick();
      lev_req = 2'd1; tick(); chk("t7_p", v_lev, 1);
      lev_req = 2'd0; tick(); chk("t7_hold", v_lev, 1);
      tick(); chk("t7_back0", v_lev, 0);
      tick();

      // en falling: current dwell, then zero, then idle with no new level
      lev_req = 2'd1; tick(); chk("t8_p", v_lev, 1);
      en = 1'b0; tick(); chk("t8_fin", v_lev, 1);
      tick(); chk("t8_park", v_lev, 0);
      repeat (4) tick(); chk("t8_idle", v_lev, 0);

      // Asynchronous reset mid-dwell
      en = 1'b1; t_dwell = 10'd5; tick();
      tick(); chk("t9_p", v_lev, 1); chk("t9_busy", busy, 1);
      #2 rst = 1'b1; #1;
      chk("t9_rst_vlev", v_lev, 0); chk("t9_rst_busy", busy, 0);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
